// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - mode codes, default step dividers and bounce direction type
package led_pkg;

    localparam logic [2:0] MODE_WALK_L = 3'd0;
    localparam logic [2:0] MODE_ROT_R  = 3'd1;
    localparam logic [2:0] MODE_SWEEP  = 3'd2;
    localparam logic [2:0] MODE_BOUNCE = 3'd3;
    localparam logic [2:0] MODE_COUNT  = 3'd4;
    localparam logic [2:0] MODE_HOLD   = 3'd5;

    // Step period minus one at 5 MHz: 200 ms, 350 ms, 500 ms, 1 s
    localparam int DEF_DIV0 = 999_999;
    localparam int DEF_DIV1 = 1_749_999;
    localparam int DEF_DIV2 = 2_499_999;
    localparam int DEF_DIV3 = 4_999_999;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

endpackage

// File: rtl/tick_div.sv
// rtl/tick_div.sv - selectable step divider: one-cycle tick every DIVk+1 enabled clocks
module tick_div
    import led_pkg::*;
#(
    parameter int DIV0  = DEF_DIV0,
    parameter int DIV1  = DEF_DIV1,
    parameter int DIV2  = DEF_DIV2,
    parameter int DIV3  = DEF_DIV3,
    parameter int DIV_W = 24
) (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] sel,
    input  logic       clr,
    output logic       tick
);

    localparam logic [DIV_W-1:0] L_DIV0 = DIV_W'(DIV0);
    localparam logic [DIV_W-1:0] L_DIV1 = DIV_W'(DIV1);
    localparam logic [DIV_W-1:0] L_DIV2 = DIV_W'(DIV2);
    localparam logic [DIV_W-1:0] L_DIV3 = DIV_W'(DIV3);

    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] w_div;
    logic             w_wrap;

    always_comb begin
        w_div = L_DIV0;
        case (sel)
            2'd0:    w_div = L_DIV0;
            2'd1:    w_div = L_DIV1;
            2'd2:    w_div = L_DIV2;
            default: w_div = L_DIV3;
        endcase
    end

    assign w_wrap = (r_cnt == w_div);
    // A clear wins over a terminal count, so a selection change never emits a tick
    assign tick   = en && !clr && w_wrap;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= w_wrap ? '0 : r_cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/led_pattern_gen.sv
// rtl/led_pattern_gen.sv - LED pattern generator: synchronised switches, step divider, six patterns
module led_pattern_gen
    import led_pkg::*;
#(
    parameter int N_LED = 4,
    parameter int DIV0  = DEF_DIV0,
    parameter int DIV1  = DEF_DIV1,
    parameter int DIV2  = DEF_DIV2,
    parameter int DIV3  = DEF_DIV3,
    parameter int DIV_W = 24
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [1:0]       speed,
    output logic [N_LED-1:0] led,
    output logic             step
);

    localparam logic [N_LED-1:0] L_ONE = N_LED'(1);
    localparam logic [N_LED-1:0] L_MSB = L_ONE << (N_LED - 1);

    logic             r_en_s1, r_en_s;
    logic [2:0]       r_mode_s1, r_mode_s, r_mode_prev;
    logic [1:0]       r_speed_s1, r_speed_s, r_speed_prev;
    logic [N_LED-1:0] r_led;
    logic [N_LED-1:0] r_ptr;
    dir_e             r_dir;
    logic             r_step;

    logic             w_mode_chg;
    logic             w_speed_chg;
    logic             w_tick;
    logic [N_LED-1:0] w_next;
    logic [N_LED-1:0] w_ptr_next;
    dir_e             w_dir_next;
    logic [N_LED-1:0] w_seed;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_en_s1      <= 1'b0;
            r_en_s       <= 1'b0;
            r_mode_s1    <= '0;
            r_mode_s     <= '0;
            r_mode_prev  <= '0;
            r_speed_s1   <= '0;
            r_speed_s    <= '0;
            r_speed_prev <= '0;
        end else begin
            r_en_s1      <= en;
            r_en_s       <= r_en_s1;
            r_mode_s1    <= mode;
            r_mode_s     <= r_mode_s1;
            r_mode_prev  <= r_mode_s;
            r_speed_s1   <= speed;
            r_speed_s    <= r_speed_s1;
            r_speed_prev <= r_speed_s;
        end
    end

    assign w_mode_chg  = (r_mode_s != r_mode_prev);
    assign w_speed_chg = (r_speed_s != r_speed_prev);

    tick_div #(
        .DIV0  (DIV0),
        .DIV1  (DIV1),
        .DIV2  (DIV2),
        .DIV3  (DIV3),
        .DIV_W (DIV_W)
    ) u_tick_div (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .en     (r_en_s),
        .sel    (r_speed_s),
        .clr    (w_mode_chg | w_speed_chg),
        .tick   (w_tick)
    );

    always_comb begin
        w_next     = r_led;
        w_ptr_next = r_ptr;
        w_dir_next = r_dir;
        case (r_mode_s)
            MODE_WALK_L: w_next = {r_led[N_LED-2:0], r_led[N_LED-1]};
            MODE_ROT_R:  w_next = {r_led[0], r_led[N_LED-1:1]};
            MODE_SWEEP: begin
                w_next     = r_led ^ r_ptr;
                w_ptr_next = (r_ptr == L_ONE) ? L_MSB : (r_ptr >> 1);
            end
            MODE_BOUNCE: begin
                // Turn around on arrival so each end bit is lit for a single tick
                if (r_dir == DIR_LEFT) begin
                    w_next = r_led << 1;
                    if (w_next[N_LED-1]) w_dir_next = DIR_RIGHT;
                end else begin
                    w_next = r_led >> 1;
                    if (w_next[0]) w_dir_next = DIR_LEFT;
                end
            end
            MODE_COUNT:  w_next = r_led + L_ONE;
            default:     w_next = r_led;
        endcase
    end

    always_comb begin
        w_seed = r_led;
        case (r_mode_s)
            MODE_WALK_L: w_seed = L_ONE;
            MODE_BOUNCE: w_seed = L_ONE;
            MODE_COUNT:  w_seed = '0;
            default:     w_seed = r_led;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_led  <= L_ONE;
            r_ptr  <= L_MSB;
            r_dir  <= DIR_LEFT;
            r_step <= 1'b0;
        end else begin
            r_step <= w_tick;
            // Pointer and direction only matter in their own modes, so reseed both on any change
            if (w_mode_chg) begin
                r_led <= w_seed;
                r_ptr <= L_MSB;
                r_dir <= DIR_LEFT;
            end else if (w_tick) begin
                r_led <= w_next;
                r_ptr <= w_ptr_next;
                r_dir <= w_dir_next;
            end
        end
    end

    assign led  = r_led;
    assign step = r_step;

endmodule

// File: tb/tb_led_pattern_gen.sv
// tb/tb_led_pattern_gen.sv - directed bench for led_pattern_gen with short dividers (3/5/7/9)
module tb_led_pattern_gen;

    logic       clk_in = 1'b0;
    logic       rst_n  = 1'b1;
    logic       en     = 1'b0;
    logic [2:0] mode   = 3'd0;
    logic [1:0] speed  = 2'd0;
    logic [3:0] led;
    logic       step;

    int checks = 0;
    int errors = 0;

    led_pattern_gen #(
        .N_LED (4),
        .DIV0  (3),
        .DIV1  (5),
        .DIV2  (7),
        .DIV3  (9),
        .DIV_W (24)
    ) dut (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .en     (en),
        .mode   (mode),
        .speed  (speed),
        .led    (led),
        .step   (step)
    );

    always #5 clk_in = ~clk_in;

    task automatic wait_step(output bit ok, output int n);
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 64) begin
            @(negedge clk_in);
            n++;
            if (step === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        en = 1'b1; mode = 3'd0; speed = 2'd0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (led !== 4'b0001) begin
            errors++; $display("FAIL reset_led got %b want %b", led, 4'b0001);
        end
        checks++;
        if (step !== 1'b0) begin
            errors++; $display("FAIL reset_step got %b want %b", step, 1'b0);
        end
        repeat (3) @(negedge clk_in);
        rst_n = 1'b1;
    endtask

    task automatic test_walk();
        logic [3:0] exp_led [5] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        bit ok; int n;
        for (int i = 0; i < 5; i++) begin
            wait_step(ok, n);
            checks++;
            if (!ok || led !== exp_led[i]) begin
                errors++; $display("FAIL walk_led[%0d] got %b ok=%0d want %b", i, led, ok, exp_led[i]);
            end
            checks++;
            if (n !== ((i == 0) ? 6 : 4)) begin
                errors++; $display("FAIL walk_gap[%0d] got %0d want %0d", i, n, (i == 0) ? 6 : 4);
            end
        end
        @(negedge clk_in);
        checks++;
        if (step !== 1'b0) begin
            errors++; $display("FAIL walk_step_width got %b want %b", step, 1'b0);
        end
    endtask

    task automatic test_bounce();
        logic [3:0] exp_led [7] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
        bit ok; int n;
        bit got;
        wait_step(ok, n);
        mode = 3'd3;
        repeat (3) @(negedge clk_in);
        checks++;
        if (led !== 4'b0001) begin
            errors++; $display("FAIL bounce_seed got %b want %b", led, 4'b0001);
        end
        for (int i = 0; i < 7; i++) begin
            wait_step(ok, n);
            got = ok;
            checks++;
            if (!got || led !== exp_led[i]) begin
                errors++; $display("FAIL bounce_led[%0d] got %b ok=%0d want %b", i, led, got, exp_led[i]);
            end
        end
    endtask

    task automatic test_sweep();
        logic [3:0] exp_led [9] = '{4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0111,
                                    4'b0011, 4'b0001, 4'b0000, 4'b1000};
        bit ok; int n;
        mode = 3'd4;
        repeat (3) @(negedge clk_in);
        checks++;
        if (led !== 4'b0000) begin
            errors++; $display("FAIL count_seed got %b want %b", led, 4'b0000);
        end
        mode = 3'd2;
        repeat (3) @(negedge clk_in);
        checks++;
        if (led !== 4'b0000) begin
            errors++; $display("FAIL sweep_seed got %b want %b", led, 4'b0000);
        end
        for (int i = 0; i < 9; i++) begin
            wait_step(ok, n);
            checks++;
            if (!ok || led !== exp_led[i]) begin
                errors++; $display("FAIL sweep_led[%0d] got %b ok=%0d want %b", i, led, ok, exp_led[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] exp_led [4] = '{4'b1001, 4'b1101, 4'b1111, 4'b1110};
        bit ok; int n;
        wait_step(ok, n);
        checks++;
        if (!ok || led !== 4'b1100) begin
            errors++; $display("FAIL sweep_pre_reset got %b ok=%0d want %b", led, ok, 4'b1100);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (led !== 4'b0001) begin
            errors++; $display("FAIL midreset_led got %b want %b", led, 4'b0001);
        end
        checks++;
        if (step !== 1'b0) begin
            errors++; $display("FAIL midreset_step got %b want %b", step, 1'b0);
        end
        repeat (2) @(negedge clk_in);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_step(ok, n);
            checks++;
            if (!ok || led !== exp_led[i]) begin
                errors++; $display("FAIL postreset_led[%0d] got %b ok=%0d want %b", i, led, ok, exp_led[i]);
            end
            if (i == 0) begin
                checks++;
                if (n !== 7) begin
                    errors++; $display("FAIL postreset_first_gap got %0d want %0d", n, 7);
                end
            end
        end
    endtask

    task automatic test_speed();
        bit ok; int n;
        speed = 2'd3;
        for (int i = 0; i < 3; i++) begin
            wait_step(ok, n);
            checks++;
            if (!ok || n !== ((i == 0) ? 13 : 10)) begin
                errors++; $display("FAIL speed_gap[%0d] got %0d ok=%0d want %0d", i, n, ok, (i == 0) ? 13 : 10);
            end
        end
    endtask

    task automatic test_count_freeze();
        bit ok; int n;
        bit seen;
        logic [3:0] e;
        logic [3:0] held;
        mode = 3'd4; speed = 2'd0;
        for (int i = 0; i < 17; i++) begin
            wait_step(ok, n);
            e = 4'(i + 1);
            checks++;
            if (!ok || led !== e) begin
                errors++; $display("FAIL count_led[%0d] got %b ok=%0d want %b", i, led, ok, e);
            end
            if (i == 0) begin
                checks++;
                if (n !== 7) begin
                    errors++; $display("FAIL dual_change_gap got %0d want %0d", n, 7);
                end
            end
        end
        en = 1'b0;
        seen = 1'b0;
        held = led;
        repeat (50) begin
            @(negedge clk_in);
            if (step !== 1'b0) seen = 1'b1;
            if (led !== held) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0 || led !== 4'b0001) begin
            errors++; $display("FAIL freeze got led=%b activity=%0d want led=%b activity=0", led, seen, 4'b0001);
        end
        en = 1'b1;
        wait_step(ok, n);
        checks++;
        if (!ok || n !== 4 || led !== 4'b0010) begin
            errors++; $display("FAIL resume got gap=%0d led=%b want gap=4 led=%b", n, led, 4'b0010);
        end
    endtask

    task automatic test_frozen_seed_rot_hold();
        logic [3:0] exp_led [4] = '{4'b1000, 4'b0100, 4'b0100, 4'b0100};
        bit ok; int n;
        bit seen;
        en = 1'b0;
        repeat (3) @(negedge clk_in);
        mode = 3'd0;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk_in);
            if (step !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (led !== 4'b0001 || seen !== 1'b0) begin
            errors++; $display("FAIL frozen_seed got led=%b step_seen=%0d want led=%b step_seen=0", led, seen, 4'b0001);
        end
        en = 1'b1; mode = 3'd1;
        for (int i = 0; i < 4; i++) begin
            wait_step(ok, n);
            checks++;
            if (!ok || led !== exp_led[i]) begin
                errors++; $display("FAIL rot_hold_led[%0d] got %b ok=%0d want %b", i, led, ok, exp_led[i]);
            end
            if (i == 1) mode = 3'd5;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_walk();
        test_bounce();
        test_sweep();
        test_reset_mid();
        test_speed();
        test_count_freeze();
        test_frozen_seed_rot_hold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
